spi_xfer_ctrl: RTL and testbench

Transfer sequencer and serial-clock generator for the SPI master's shift register. It divides the Wishbone clock into sclk and emits one-cycle edge strobes (cpol_1 for rising sclk, cpol_0 for falling sclk) that drive the shift register's transmit and receive timing. It counts 2*len sclk edges per character, frames each character with slave-select setup and hold phases, and raises tip, last and an interrupt.

---
 rtl/spi_xfer_ctrl.sv | 132 +++++++++++++
 tb/tb_spi_xfer_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_xfer_ctrl.sv
// SPI master transfer sequencer: sclk divider, edge strobes,
// slave-select framing and end-of-character interrupt.
module spi_xfer_ctrl #(
  parameter int SPI_CHAR_LEN_BITS = 7,
  parameter int SPI_DIVIDER_LEN   = 16,
  parameter int SPI_SS_NB         = 8
) (
  input  logic                         wb_clk_in,
  input  logic                         wb_rst,
  input  logic                         go,
  input  logic [SPI_DIVIDER_LEN-1:0]   divider,
  input  logic [SPI_CHAR_LEN_BITS-1:0] len,
  input  logic                         cpol,
  input  logic [SPI_SS_NB-1:0]         ss_sel,
  input  logic                         ass,
  input  logic                         ie,
  input  logic                         int_ack,
  output logic                         sclk_pad_o,
  output logic                         cpol_1,
  output logic                         cpol_0,
  output logic                         tip,
  output logic                         last,
  output logic [SPI_SS_NB-1:0]         ss_pad_o,
  output logic                         irq
);

  localparam int EW = SPI_CHAR_LEN_BITS + 2;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SETUP = 2'd1;
  localparam logic [1:0] XFER  = 2'd2;
  localparam logic [1:0] HOLD  = 2'd3;

  logic [1:0]                 state;
  logic [1:0]                 state_nxt;
  logic                       go_q;
  logic                       start;
  logic                       cnt_zero;
  logic [SPI_DIVIDER_LEN-1:0] cnt;
  logic [SPI_DIVIDER_LEN-1:0] div_q;
  logic [EW-1:0]              edge_cnt;
  logic [EW-1:0]              edge_init;
  logic                       cpol_q;
  logic                       ie_q;
  logic [SPI_SS_NB-1:0]       sel_q;
  logic [SPI_SS_NB-1:0]       sel_nxt;

  assign start    = (state == IDLE) && go && !go_q;
  assign cnt_zero = (cnt == '0);
  assign sel_nxt  = start ? ss_sel : sel_q;

  // len==0 encodes a full 2^SPI_CHAR_LEN_BITS-bit character
  assign edge_init = {(len == '0), len, 1'b0};

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SETUP;
      SETUP:   if (cnt_zero) state_nxt = XFER;
      XFER:    if (cnt_zero && edge_cnt == EW'(1)) state_nxt = HOLD;
      HOLD:    if (cnt_zero) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_in) begin
    if (!wb_rst) begin
      state      <= IDLE;
      go_q       <= 1'b0;
      cnt        <= '0;
      div_q      <= '0;
      edge_cnt   <= '0;
      cpol_q     <= 1'b0;
      ie_q       <= 1'b0;
      sel_q      <= '0;
      sclk_pad_o <= 1'b0;
      cpol_0     <= 1'b0;
      cpol_1     <= 1'b0;
      tip        <= 1'b0;
      last       <= 1'b0;
      ss_pad_o   <= '1;
      irq        <= 1'b0;
    end else begin
      go_q     <= go;
      state    <= state_nxt;
      cpol_0   <= 1'b0;
      cpol_1   <= 1'b0;
      tip      <= (state_nxt == XFER);
      ss_pad_o <= ass ? ((state_nxt != IDLE) ? ~sel_nxt : '1)
                      : ~ss_sel;
      last     <= (state == XFER) &&
                  (cnt_zero ? (edge_cnt == EW'(2))
                            : (edge_cnt == EW'(1)));
      case (state)
        IDLE: begin
          sclk_pad_o <= cpol;
          if (start) begin
            div_q    <= divider;
            cnt      <= divider;
            edge_cnt <= edge_init;
            cpol_q   <= cpol;
            ie_q     <= ie;
            sel_q    <= ss_sel;
          end
        end
        SETUP: begin
          sclk_pad_o <= cpol_q;
          cnt        <= cnt_zero ? div_q : cnt - 1'b1;
        end
        XFER: begin
          if (cnt_zero) begin
            cnt        <= div_q;
            sclk_pad_o <= ~sclk_pad_o;
            cpol_1     <= ~sclk_pad_o;
            cpol_0     <= sclk_pad_o;
            edge_cnt   <= edge_cnt - 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          cnt <= cnt_zero ? div_q : cnt - 1'b1;
        end
      endcase
      if (state == HOLD && cnt_zero && ie_q)
        irq <= 1'b1;
      else if (int_ack)
        irq <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Scoreboard bench for spi_xfer_ctrl: strobe timing/kind, framing,
// tip/last, irq and reset abort.
module tb_spi_xfer_ctrl;

  logic        wb_clk_in = 1'b0;
  logic        wb_rst    = 1'b0;
  logic        go        = 1'b0;
  logic [15:0] divider   = '0;
  logic [6:0]  len       = '0;
  logic        cpol      = 1'b0;
  logic [7:0]  ss_sel    = '0;
  logic        ass       = 1'b1;
  logic        ie        = 1'b0;
  logic        int_ack   = 1'b0;
  logic        sclk_pad_o;
  logic        cpol_1;
  logic        cpol_0;
  logic        tip;
  logic        last;
  logic [7:0]  ss_pad_o;
  logic        irq;

  spi_xfer_ctrl dut (
    .wb_clk_in  (wb_clk_in),
    .wb_rst     (wb_rst),
    .go         (go),
    .divider    (divider),
    .len        (len),
    .cpol       (cpol),
    .ss_sel     (ss_sel),
    .ass        (ass),
    .ie         (ie),
    .int_ack    (int_ack),
    .sclk_pad_o (sclk_pad_o),
    .cpol_1     (cpol_1),
    .cpol_0     (cpol_0),
    .tip        (tip),
    .last       (last),
    .ss_pad_o   (ss_pad_o),
    .irq        (irq)
  );

  always #5 wb_clk_in = ~wb_clk_in;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  typedef struct {
    int t;
    bit rise;
    bit lst;
  } edge_t;

  edge_t sb[$];

  task automatic ack();
    @(negedge wb_clk_in);
    int_ack = 1'b1;
    @(negedge wb_clk_in);
    int_ack = 1'b0;
    chk("irq_ack", irq, 0);
  endtask

  task automatic run_xfer(input int d, input int l, input bit pol,
                          input bit ien, input logic [7:0] sel,
                          input bit mid);
    int n;
    int tend;
    int tips;
    bit last_prev;
    edge_t e;
    logic [7:0] nsel;
    nsel = ~sel;
    n = (l == 0) ? 128 : l;
    @(negedge wb_clk_in);
    go = 1'b0;
    divider = 16'(d);
    len = 7'(l);
    cpol = pol;
    ie = ien;
    ss_sel = sel;
    ass = 1'b1;
    for (int k = 1; k <= 2 * n; k++) begin
      e.t = 1 + (k + 1) * (d + 1);
      e.rise = ((k & 1) != 0) != pol;
      e.lst = (k == 2 * n);
      sb.push_back(e);
    end
    @(negedge wb_clk_in);
    chk("sclk_idle", sclk_pad_o, pol);
    go = 1'b1;
    tend = 1 + (2 * n + 2) * (d + 1);
    tips = 0;
    last_prev = 1'b0;
    for (int t = 1; t <= tend + 4; t++) begin
      @(negedge wb_clk_in);
      if (mid && t == 6) begin
        go = 1'b0;
        divider = 16'd0;
        len = 7'd1;
      end
      if (mid && t == 7) go = 1'b1;
      if (t == 1) chk("ss_setup", ss_pad_o, nsel);
      if (t == d + 1) chk("tip_setup", tip, 0);
      if (t == d + 2) chk("tip_rise", tip, 1);
      if (t == tend - 1) chk("ss_hold", ss_pad_o, nsel);
      if (t == tend) begin
        chk("ss_end", ss_pad_o, 8'hFF);
        chk("irq_end", irq, ien);
        chk("sclk_end", sclk_pad_o, pol);
      end
      tips += int'(tip);
      if (cpol_0 || cpol_1) begin
        if (sb.size() == 0) begin
          chk("extra_strobe_t", t, 0);
        end else begin
          e = sb.pop_front();
          chk("strobe_t", t, e.t);
          chk("strobe_kind", {cpol_1, cpol_0},
              e.rise ? 2'b10 : 2'b01);
          chk("last_before", last_prev, e.lst);
        end
      end
      last_prev = last;
    end
    chk("tip_cycles", tips, 2 * n * (d + 1));
    chk("missing_strobes", sb.size(), 0);
    sb.delete();
    go = 1'b0;
  endtask

  initial begin
    bit seen;
    wb_rst = 1'b0;
    repeat (3) @(negedge wb_clk_in);
    chk("rst_sclk", sclk_pad_o, 0);
    chk("rst_strobes", {cpol_1, cpol_0}, 0);
    chk("rst_tip", tip, 0);
    chk("rst_last", last, 0);
    chk("rst_ss", ss_pad_o, 8'hFF);
    chk("rst_irq", irq, 0);
    wb_rst = 1'b1;

    run_xfer(1, 4, 1'b0, 1'b1, 8'h01, 1'b0);
    run_xfer(0, 1, 1'b1, 1'b1, 8'h02, 1'b0);
    run_xfer(0, 0, 1'b0, 1'b1, 8'h80, 1'b0);
    run_xfer(2, 3, 1'b0, 1'b1, 8'h04, 1'b1);
    run_xfer(0, 1, 1'b0, 1'b1, 8'h04, 1'b0);

    int_ack = 1'b1;
    run_xfer(1, 2, 1'b0, 1'b1, 8'h08, 1'b0);
    int_ack = 1'b0;
    ack();
    run_xfer(1, 2, 1'b0, 1'b0, 8'h08, 1'b0);

    @(negedge wb_clk_in);
    divider = 16'd3;
    len = 7'd4;
    cpol = 1'b0;
    ss_sel = 8'h10;
    ie = 1'b1;
    @(negedge wb_clk_in);
    go = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge wb_clk_in);
      seen = sclk_pad_o && tip;
    end
    chk("sclk_high_seen", seen, 1);
    wb_rst = 1'b0;
    @(negedge wb_clk_in);
    chk("abort_sclk", sclk_pad_o, 0);
    chk("abort_strobes", {cpol_1, cpol_0}, 0);
    chk("abort_tip", tip, 0);
    chk("abort_last", last, 0);
    chk("abort_ss", ss_pad_o, 8'hFF);
    chk("abort_irq", irq, 0);
    wb_rst = 1'b1;
    @(negedge wb_clk_in);
    chk("restart_ss", ss_pad_o, 8'hEF);
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge wb_clk_in);
      seen = (ss_pad_o == 8'hFF);
    end
    chk("restart_done", seen, 1);
    chk("restart_irq", irq, 1);
    go = 1'b0;

    ass = 1'b0;
    ss_sel = 8'h3C;
    repeat (2) @(negedge wb_clk_in);
    chk("ass0_ss_a", ss_pad_o, 8'hC3);
    ss_sel = 8'hA5;
    @(negedge wb_clk_in);
    chk("ass0_ss_b", ss_pad_o, 8'h5A);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
